// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - data SRAM responder: byte-enabled word RAM plus LED/timer/scratch MMIO window
// Single-cycle requests, registered read data one cycle later, read-first on same-word writes.
module data_sram_responder #(
  parameter int          ADDR_W    = 12,
  parameter logic [15:0] MMIO_BASE = 16'hBFAF,
  parameter bit          TIMER_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led,
  output logic [31:0] timer_value
);

  localparam int          DEPTH       = 1 << ADDR_W;
  localparam logic [15:0] LED_OFF     = 16'hF000;
  localparam logic [15:0] TIMER_OFF   = 16'hE000;
  localparam logic [15:0] SCRATCH_OFF = 16'hFFF0;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       timer;
  logic [31:0]       scratch;
  logic [31:0]       mmio_rdata;
  logic [15:0]       led_next;
  logic [15:0]       offset;
  logic [ADDR_W-1:0] index;
  logic              mmio_hit;
  logic              wr;
  logic              ram_wr;
  logic              led_wr;
  logic              timer_wr;
  logic              scratch_wr;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  lanes);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  assign mmio_hit   = (data_sram_addr[31:16] == MMIO_BASE);
  assign offset     = data_sram_addr[15:0];
  assign index      = data_sram_addr[ADDR_W+1:2];
  assign wr         = data_sram_en && (data_sram_wen != 4'd0);
  assign ram_wr     = wr && !mmio_hit;
  assign led_wr     = wr && mmio_hit && (offset == LED_OFF);
  assign timer_wr   = wr && mmio_hit && (offset == TIMER_OFF);
  assign scratch_wr = wr && mmio_hit && (offset == SCRATCH_OFF);

  assign timer_value = timer;

  always_comb begin
    mmio_rdata = 32'd0;
    case (offset)
      LED_OFF:     mmio_rdata = {16'd0, led};
      TIMER_OFF:   mmio_rdata = timer;
      SCRATCH_OFF: mmio_rdata = scratch;
      default:     mmio_rdata = 32'd0;
    endcase
  end

  // LED only has two byte lanes; upper enables are dropped.
  always_comb begin
    led_next = led;
    if (data_sram_wen[0]) led_next[7:0]  = data_sram_wdata[7:0];
    if (data_sram_wen[1]) led_next[15:8] = data_sram_wdata[15:8];
  end

  // RAM contents survive reset, so the array has no reset branch.
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) mem[index][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_sram_rdata <= 32'd0;
    end else if (data_sram_en) begin
      data_sram_rdata <= mmio_hit ? mmio_rdata : mem[index];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led <= 16'd0;
    end else if (led_wr) begin
      led <= led_next;
    end
  end

  // A write suppresses that cycle's increment; unwritten lanes keep the pre-increment value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= 32'd0;
    end else if (timer_wr) begin
      timer <= merge_bytes(timer, data_sram_wdata, data_sram_wen);
    end else if (TIMER_EN) begin
      timer <= timer + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scratch <= 32'd0;
    end else if (scratch_wr) begin
      scratch <= merge_bytes(scratch, data_sram_wdata, data_sram_wen);
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// tb/tb_data_sram_responder.sv - table-driven bench for data_sram_responder
module tb_data_sram_responder;

  logic        clk;
  logic        reset;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [15:0] led;
  logic [31:0] timer_value;

  int checks = 0;
  int errors = 0;

  data_sram_responder #(.ADDR_W(12), .MMIO_BASE(16'hBFAF), .TIMER_EN(1'b1)) dut (
    .clk             (clk),
    .reset           (reset),
    .data_sram_en    (en),
    .data_sram_wen   (wen),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .led             (led),
    .timer_value     (timer_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
    logic        chk_led;
    logic [15:0] exp_led;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic e, input logic [3:0] w, input logic [31:0] a,
                              input logic [31:0] d, input logic c, input logic [31:0] x,
                              input logic cl, input logic [15:0] xl);
    vec_t v;
    v.en = e; v.wen = w; v.addr = a; v.wdata = d;
    v.chk = c; v.exp = x; v.chk_led = cl; v.exp_led = xl;
    return v;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    en = e; wen = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; wen = 4'd0; addr = 32'd0; wdata = 32'd0;

    // ram data path: partial write, read-first, wrap, en=0 hold
    vecs.push_back(mk(1, 4'hF, 32'h0000_0100, 32'h1122_3344, 0, 32'h0, 0, 16'h0));
    vecs.push_back(mk(1, 4'h2, 32'h0000_0100, 32'h0000_AA00, 1, 32'h1122_3344, 0, 16'h0));
    vecs.push_back(mk(1, 4'h0, 32'h0000_0100, 32'h0, 1, 32'h1122_AA44, 0, 16'h0));
    vecs.push_back(mk(0, 4'h0, 32'h0000_0000, 32'h0, 1, 32'h1122_AA44, 0, 16'h0));
    vecs.push_back(mk(1, 4'hF, 32'h0000_0200, 32'h0, 0, 32'h0, 0, 16'h0));
    vecs.push_back(mk(1, 4'hF, 32'h0000_0200, 32'hDEAD_BEEF, 1, 32'h0, 0, 16'h0));
    vecs.push_back(mk(1, 4'h0, 32'h0000_0200, 32'h0, 1, 32'hDEAD_BEEF, 0, 16'h0));
    vecs.push_back(mk(1, 4'hF, 32'h0000_4000, 32'h5A5A_5A5A, 0, 32'h0, 0, 16'h0));
    vecs.push_back(mk(1, 4'h0, 32'h0000_0000, 32'h0, 1, 32'h5A5A_5A5A, 0, 16'h0));
    vecs.push_back(mk(1, 4'hF, 32'h0000_3000, 32'h600D_F00D, 0, 32'h0, 0, 16'h0));
    vecs.push_back(mk(1, 4'hF, 32'h0000_0300, 32'hCAFE_F00D, 0, 32'h0, 0, 16'h0));
    // mmio: led, scratch, unmapped, ram alias untouched
    vecs.push_back(mk(1, 4'hF, 32'hBFAF_F000, 32'h1234_ABCD, 1, 32'h0, 1, 16'hABCD));
    vecs.push_back(mk(1, 4'h0, 32'hBFAF_F000, 32'h0, 1, 32'h0000_ABCD, 1, 16'hABCD));
    vecs.push_back(mk(1, 4'hC, 32'hBFAF_F000, 32'hFFFF_0000, 1, 32'h0000_ABCD, 1, 16'hABCD));
    vecs.push_back(mk(1, 4'h0, 32'hBFAF_F000, 32'h0, 1, 32'h0000_ABCD, 1, 16'hABCD));
    vecs.push_back(mk(1, 4'h5, 32'hBFAF_FFF0, 32'hAABB_CCDD, 1, 32'h0, 0, 16'h0));
    vecs.push_back(mk(1, 4'h0, 32'hBFAF_FFF0, 32'h0, 1, 32'h00BB_00DD, 0, 16'h0));
    vecs.push_back(mk(1, 4'hF, 32'hBFAF_1234, 32'hFFFF_FFFF, 1, 32'h0, 0, 16'h0));
    vecs.push_back(mk(1, 4'h0, 32'hBFAF_1234, 32'h0, 1, 32'h0, 0, 16'h0));
    vecs.push_back(mk(1, 4'h0, 32'h0000_3000, 32'h0, 1, 32'h600D_F00D, 1, 16'hABCD));
    // timer: write at N, idle, read at N+2, then partial write suppressing increment
    vecs.push_back(mk(1, 4'hF, 32'hBFAF_E000, 32'h0000_FFFE, 0, 32'h0, 0, 16'h0));
    vecs.push_back(mk(0, 4'h0, 32'h0000_0000, 32'h0, 0, 32'h0, 0, 16'h0));
    vecs.push_back(mk(1, 4'h0, 32'hBFAF_E000, 32'h0, 1, 32'h0000_FFFF, 0, 16'h0));
    vecs.push_back(mk(1, 4'h1, 32'hBFAF_E000, 32'h0000_00AA, 0, 32'h0, 0, 16'h0));
    vecs.push_back(mk(1, 4'h0, 32'hBFAF_E000, 32'h0, 1, 32'h0001_00AA, 0, 16'h0));

    repeat (2) @(posedge clk);
    #1;
    chk32("rst_rdata", rdata, 32'h0);
    chk32("rst_led", {16'h0, led}, 32'h0);
    chk32("rst_timer", timer_value, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk32("timer_run", timer_value, 32'h1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata);
      if (vecs[i].chk) chk32($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp);
      if (vecs[i].chk_led) chk32($sformatf("vec%0d_led", i), {16'h0, led}, {16'h0, vecs[i].exp_led});
    end

    // reset lands while a ram read is in flight
    @(negedge clk);
    en = 1'b1; wen = 4'h0; addr = 32'h0000_0300; wdata = 32'h0;
    #2 reset = 1'b1;
    #1;
    chk32("async_rdata", rdata, 32'h0);
    chk32("async_led", {16'h0, led}, 32'h0);
    chk32("async_timer", timer_value, 32'h0);
    @(posedge clk);
    #1;
    chk32("dropped_read", rdata, 32'h0);
    @(negedge clk);
    reset = 1'b0; en = 1'b0;
    drive(1, 4'h0, 32'h0000_0300, 32'h0);
    chk32("ram_kept", rdata, 32'hCAFE_F00D);
    chk32("led_after_rst", {16'h0, led}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
